// File: rtl/msf_pkg.sv
// Shared definitions for the MSF time sequencer: BCD digit widths, the
// {synced, armed} state encoding and the decoded-frame plausibility check.
package msf_pkg;

  localparam int HOUR_H_W = 2;
  localparam int HOUR_L_W = 4;
  localparam int MIN_H_W  = 3;
  localparam int MIN_L_W  = 4;
  localparam int SEC_H_W  = 3;
  localparam int SEC_L_W  = 4;

  // Bit 1 = synced (clock holds radio time), bit 0 = armed (frame pending)
  typedef enum logic [1:0] {
    ST_WAIT         = 2'b00,
    ST_ARMED        = 2'b01,
    ST_LOCKED       = 2'b10,
    ST_LOCKED_ARMED = 2'b11
  } state_t;

  // True when the decoded HH:MM is a legal 24-hour BCD time
  function automatic logic bcd_time_plausible(
    input logic [HOUR_H_W-1:0] hour_h,
    input logic [HOUR_L_W-1:0] hour_l,
    input logic [MIN_H_W-1:0]  min_h,
    input logic [MIN_L_W-1:0]  min_l
  );
    return (hour_h <= 2'd2) && (hour_l <= 4'd9) &&
           !((hour_h == 2'd2) && (hour_l > 4'd3)) &&
           (min_h <= 3'd5) && (min_l <= 4'd9);
  endfunction

endpackage

// File: rtl/msf_sec_prescaler.sv
// Second prescaler: counts 0..TICK_DIV-1 and wraps. wrap_o is high while
// the count sits on its last value; clr_i restarts the count at 0.
module msf_sec_prescaler #(
  parameter int unsigned TICK_DIV = 32768
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic wrap_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == LAST);

  // Next count: clear has priority, otherwise increment with wrap
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msf_time_sync.sv
// MSF time sequencer: drives the seconds increment and the load strobe of
// the HH:MM:SS digit chain. A plausible decoded frame is held pending and
// loaded (seconds 00) at the next minute marker, which also re-phases the
// second prescaler.
// Optional feature macro: MSF_HOLDOVER_EN -- drop lock after HOLDOVER_MIN
// minute markers pass without a load.
module msf_time_sync
  import msf_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 32768,
  parameter int unsigned HOLDOVER_MIN = 60
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                minute_i,
  input  logic                frame_valid_i,
  input  logic [HOUR_H_W-1:0] frame_hour_h_i,
  input  logic [HOUR_L_W-1:0] frame_hour_l_i,
  input  logic [MIN_H_W-1:0]  frame_min_h_i,
  input  logic [MIN_L_W-1:0]  frame_min_l_i,
  output logic                inc_o,
  output logic                load_o,
  output logic [HOUR_H_W-1:0] load_hour_h_o,
  output logic [HOUR_L_W-1:0] load_hour_l_o,
  output logic [MIN_H_W-1:0]  load_min_h_o,
  output logic [MIN_L_W-1:0]  load_min_l_o,
  output logic [SEC_H_W-1:0]  load_sec_h_o,
  output logic [SEC_L_W-1:0]  load_sec_l_o,
  output logic                frame_err_o,
  output logic                synced_o
);

  state_t state_q, state_d;

  logic plausible, accept, reject, do_load, wrap, hold_expire;
  logic inc_q, load_q, err_q;

  logic [HOUR_H_W-1:0] pend_hour_h_q, load_hour_h_q;
  logic [HOUR_L_W-1:0] pend_hour_l_q, load_hour_l_q;
  logic [MIN_H_W-1:0]  pend_min_h_q,  load_min_h_q;
  logic [MIN_L_W-1:0]  pend_min_l_q,  load_min_l_q;

  assign plausible = bcd_time_plausible(frame_hour_h_i, frame_hour_l_i,
                                        frame_min_h_i, frame_min_l_i);
  assign accept    = frame_valid_i & plausible;
  assign reject    = frame_valid_i & ~plausible;
  // A marker only loads when a frame is pending; it uses the value pending
  // before this cycle, even if a new frame is accepted alongside it
  assign do_load   = minute_i & state_q[0];

  msf_sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (do_load),
    .wrap_o (wrap)
  );

`ifdef MSF_HOLDOVER_EN
  localparam int unsigned HW = $clog2(HOLDOVER_MIN + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLDOVER_MIN);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // Saturating count of markers that brought no load; a load restarts it
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (do_load) begin
      hold_cnt_d = '0;
    end else if (minute_i && (hold_cnt_q != HOLD_LIMIT)) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end
  end

  assign hold_expire = (hold_cnt_d == HOLD_LIMIT);

  // Holdover counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_expire = 1'b0;
`endif

  // Next state: frames arm, markers consume the pending frame and lock
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT:         if (accept)   state_d = ST_ARMED;
      ST_ARMED:        if (minute_i) state_d = accept ? ST_LOCKED_ARMED : ST_LOCKED;
      ST_LOCKED:       if (accept)   state_d = ST_LOCKED_ARMED;
      ST_LOCKED_ARMED: if (minute_i && !accept) state_d = ST_LOCKED;
      default:         state_d = ST_WAIT;
    endcase
    if (hold_expire) begin
      state_d = state_t'({1'b0, state_d[0]});
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending frame: every accepted frame overwrites it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_hour_h_q <= '0;
      pend_hour_l_q <= '0;
      pend_min_h_q  <= '0;
      pend_min_l_q  <= '0;
    end else if (accept) begin
      pend_hour_h_q <= frame_hour_h_i;
      pend_hour_l_q <= frame_hour_l_i;
      pend_min_h_q  <= frame_min_h_i;
      pend_min_l_q  <= frame_min_l_i;
    end
  end

  // Registered strobes and load values; load values hold between loads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inc_q         <= 1'b0;
      load_q        <= 1'b0;
      err_q         <= 1'b0;
      load_hour_h_q <= '0;
      load_hour_l_q <= '0;
      load_min_h_q  <= '0;
      load_min_l_q  <= '0;
    end else begin
      inc_q  <= wrap & ~do_load;
      load_q <= do_load;
      err_q  <= reject;
      if (do_load) begin
        load_hour_h_q <= pend_hour_h_q;
        load_hour_l_q <= pend_hour_l_q;
        load_min_h_q  <= pend_min_h_q;
        load_min_l_q  <= pend_min_l_q;
      end
    end
  end

  assign inc_o         = inc_q;
  assign load_o        = load_q;
  assign frame_err_o   = err_q;
  assign synced_o      = state_q[1];
  assign load_hour_h_o = load_hour_h_q;
  assign load_hour_l_o = load_hour_l_q;
  assign load_min_h_o  = load_min_h_q;
  assign load_min_l_o  = load_min_l_q;
  assign load_sec_h_o  = '0;
  assign load_sec_l_o  = '0;

endmodule
